// File: rtl/pwm_audio_dac.sv
// Sample-stream to single-bit PWM pin, one sample latched per PWM period.
// Define PWM_AUDIO_DAC_DITHER_EN to add 1-LSB LFSR dither to each latched sample.
module pwm_audio_dac #(
    parameter int WIDTH    = 9,
    parameter int PRESCALE = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_sample,
    input  logic             i_sample_valid,
    input  logic             i_clear_underrun,
    output logic             o_sample_req,
    output logic             o_pwm,
    output logic             o_period_stb,
    output logic             o_underrun
);

    localparam int PW = $clog2(PRESCALE) + 1;
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    pre_q, pre_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] duty_q, duty_d, new_duty;
    logic             req_q, req_d;
    logic             pwm_q, pwm_d;
    logic             stb_q;
    logic             underrun_q, underrun_d;
    logic             cnt_en, last_cnt;

`ifdef PWM_AUDIO_DAC_DITHER_EN
    logic [15:0]      lfsr_q, lfsr_d;
    logic [WIDTH:0]   dith_sum;

    always_comb begin
        lfsr_d = lfsr_q;
        if (last_cnt) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
        dith_sum = {1'b0, i_sample} + (WIDTH + 1)'(lfsr_q[0]);
        new_duty = dith_sum[WIDTH] ? CNT_MAX : dith_sum[WIDTH-1:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    always_comb begin
        new_duty = i_sample;
    end
`endif

    always_comb begin
        cnt_en   = (pre_q == PRE_LAST);
        pre_d    = cnt_en ? '0 : pre_q + PW'(1);
        cnt_d    = cnt_en ? cnt_q + WIDTH'(1) : cnt_q;
        last_cnt = cnt_en && (cnt_q == CNT_MAX);

        // Request is registered, so look one state ahead for the cycle before last-count.
        if (PRESCALE == 1) begin
            req_d = (cnt_d == CNT_MAX - WIDTH'(1));
        end else begin
            req_d = (cnt_d == CNT_MAX) && (pre_d == PRE_LAST - PW'(1));
        end

        duty_d     = duty_q;
        underrun_d = underrun_q;
        if (i_clear_underrun) begin
            underrun_d = 1'b0;
        end
        if (last_cnt) begin
            if (i_sample_valid) begin
                duty_d = new_duty;
            end else begin
                underrun_d = 1'b1;
            end
        end

        pwm_d = (cnt_d < duty_d);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pre_q      <= '0;
            cnt_q      <= '0;
            duty_q     <= '0;
            req_q      <= 1'b0;
            pwm_q      <= 1'b0;
            stb_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            cnt_q      <= cnt_d;
            duty_q     <= duty_d;
            req_q      <= req_d;
            pwm_q      <= pwm_d;
            stb_q      <= last_cnt;
            underrun_q <= underrun_d;
        end
    end

    assign o_sample_req = req_q;
    assign o_pwm        = pwm_q;
    assign o_period_stb = stb_q;
    assign o_underrun   = underrun_q;

endmodule

// File: tb/tb_pwm_audio_dac.sv
// Bench for pwm_audio_dac: PRESCALE=1 and PRESCALE=4 instances against a
// period-arithmetic model, plus hand-computed per-period high-time checks.
module tb_pwm_audio_dac;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0, rst4_n = 1'b0;
    logic [8:0] sample0 = '0, sample4 = '0;
    logic       valid0 = 1'b1, valid4 = 1'b1;
    logic       clr0 = 1'b0, clr4 = 1'b0;
    logic       req0, pwm0, stb0, und0;
    logic       req4, pwm4, stb4, und4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_audio_dac #(.WIDTH(9), .PRESCALE(1)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sample(sample0), .i_sample_valid(valid0),
        .i_clear_underrun(clr0), .o_sample_req(req0), .o_pwm(pwm0),
        .o_period_stb(stb0), .o_underrun(und0)
    );

    pwm_audio_dac #(.WIDTH(9), .PRESCALE(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst4_n), .i_sample(sample4), .i_sample_valid(valid4),
        .i_clear_underrun(clr4), .o_sample_req(req4), .o_pwm(pwm4),
        .o_period_stb(stb4), .o_underrun(und4)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int dith(input int s, input logic [15:0] lf);
`ifdef PWM_AUDIO_DAC_DITHER_EN
        int v = s + int'(lf[0]);
        return (v > 511) ? 511 : v;
`else
        return s;
`endif
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    // Expected {pwm, stb, req} from elapsed clock count since reset release.
    function automatic logic [2:0] model_out(input longint t, input int p, input int duty);
        longint per = 512 * p;
        longint pos = t % per;
        longint cnt = pos / p;
        return {cnt < duty, (pos == 0) && (t > 0), pos == per - 2};
    endfunction

    longint      t0 = 0, t4 = 0;
    int          duty_m0 = 0, duty_m4 = 0;
    logic        und_m0 = 1'b0, und_m4 = 1'b0;
    logic [15:0] lf0 = 16'hACE1, lf4 = 16'hACE1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t0 = 0; duty_m0 = 0; und_m0 = 1'b0; lf0 = 16'hACE1;
        end else begin
            if (t0 % 512 == 511) begin
                if (valid0) duty_m0 = dith(int'(sample0), lf0);
                und_m0 = !valid0 ? 1'b1 : (clr0 ? 1'b0 : und_m0);
                lf0 = lfsr_step(lf0);
            end else if (clr0) begin
                und_m0 = 1'b0;
            end
            t0++;
        end
    end

    always @(posedge clk or negedge rst4_n) begin
        if (!rst4_n) begin
            t4 = 0; duty_m4 = 0; und_m4 = 1'b0; lf4 = 16'hACE1;
        end else begin
            if (t4 % 2048 == 2047) begin
                if (valid4) duty_m4 = dith(int'(sample4), lf4);
                und_m4 = !valid4 ? 1'b1 : (clr4 ? 1'b0 : und_m4);
                lf4 = lfsr_step(lf4);
            end else if (clr4) begin
                und_m4 = 1'b0;
            end
            t4++;
        end
    end

    always @(negedge clk) begin
        logic [2:0] e0, e4;
        e0 = model_out(t0, 1, duty_m0);
        e4 = model_out(t4, 4, duty_m4);
        chk("p1_pwm", int'(pwm0), int'(e0[2]));
        chk("p1_stb", int'(stb0), int'(e0[1]));
        chk("p1_req", int'(req0), int'(e0[0]));
        chk("p1_underrun", int'(und0), int'(und_m0));
        chk("p4_pwm", int'(pwm4), int'(e4[2]));
        chk("p4_stb", int'(stb4), int'(e4[1]));
        chk("p4_req", int'(req4), int'(e4[0]));
        chk("p4_underrun", int'(und4), int'(und_m4));
    end

    task automatic wait_stb(input int which);
        int n = 0;
        while (((which == 0) ? stb0 : stb4) !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 5000) begin
            errors++;
            $display("FAIL wait_stb%0d: no period strobe within %0d clocks", which, n);
        end
    endtask

    // Called on the strobe cycle; runs to the next strobe.
    task automatic check_period(input int which, input int exp_duty);
        int p   = (which == 0) ? 1 : 4;
        int len = 0, high = 0, req_off = -1;
        int alt = (exp_duty + 1 > 511) ? 511 : exp_duty + 1;
        do begin
            if (((which == 0) ? pwm0 : pwm4) === 1'b1) high++;
            if (((which == 0) ? req0 : req4) === 1'b1 && req_off < 0) req_off = len;
            len++;
            @(negedge clk);
        end while (((which == 0) ? stb0 : stb4) !== 1'b1 && len < 5000);
        chk($sformatf("period_len%0d", which), len, 512 * p);
        chk($sformatf("req_offset%0d", which), req_off, 512 * p - 2);
`ifdef PWM_AUDIO_DAC_DITHER_EN
        chk($sformatf("high_time%0d_d%0d", which, exp_duty),
            (high == alt * p) ? exp_duty * p : high, exp_duty * p);
`else
        chk($sformatf("high_time%0d_d%0d", which, exp_duty), high, exp_duty * p);
        if (alt < 0) chk("unused", alt, 0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        sample0 = 9'd0; valid0 = 1'b1; sample4 = 9'd10; valid4 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pwm", int'(pwm0), 0);
        chk("rst_stb", int'(stb0), 0);
        chk("rst_req", int'(req0), 0);
        chk("rst_underrun", int'(und0), 0);
        rst_n = 1'b1; rst4_n = 1'b1;

        wait_stb(0);
        repeat (3) check_period(0, 0);
        chk("silent_underrun", int'(und0), 0);

        sample0 = 9'd128;
        check_period(0, 0);
        chk("rise_on_stb", int'(pwm0), 1);
        repeat (2) check_period(0, 128);

        sample0 = 9'd511;
        check_period(0, 128);
        check_period(0, 511);
        fork
            check_period(0, 511);
            begin repeat (100) @(negedge clk); sample0 = 9'd64; end
        join
        check_period(0, 64);

        sample0 = 9'd200;
        check_period(0, 64);
        check_period(0, 200);
        fork
            check_period(0, 200);
            begin
                repeat (508) @(negedge clk);
                valid0 = 1'b0; sample0 = 9'd77;
                repeat (4) @(negedge clk);
                valid0 = 1'b1; sample0 = 9'd200;
            end
        join
        chk("underrun_set", int'(und0), 1);
        sample0 = 9'd300;
        fork
            check_period(0, 200);
            begin repeat (50) @(negedge clk); clr0 = 1'b1; @(negedge clk); clr0 = 1'b0; end
        join
        chk("underrun_clear", int'(und0), 0);
        fork
            check_period(0, 300);
            begin
                repeat (511) @(negedge clk);
                valid0 = 1'b0; clr0 = 1'b1;
                @(negedge clk);
                valid0 = 1'b1; clr0 = 1'b0;
            end
        join
        chk("set_beats_clear", int'(und0), 1);
        check_period(0, 300);

        wait_stb(1);
        repeat (2) check_period(1, 10);
        repeat (5) @(negedge clk);
        chk("p4_pwm_before_rst", int'(pwm4), 1);
        #2 rst4_n = 1'b0;
        #1;
        chk("async_rst_pwm", int'(pwm4), 0);
        chk("async_rst_stb", int'(stb4), 0);
        chk("async_rst_req", int'(req4), 0);
        chk("async_rst_underrun", int'(und4), 0);
        @(negedge clk);
        rst4_n = 1'b1;
        wait_stb(1);
        check_period(1, 10);

`ifdef PWM_AUDIO_DAC_DITHER_EN
        sample0 = 9'd100;
        wait_stb(0);
        check_period(0, 300);
        repeat (64) check_period(0, 100);
        sample0 = 9'd511;
        check_period(0, 100);
        repeat (4) check_period(0, 511);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
